motoro3_pwm_multich_gen: RTL and testbench

Parametrised NCH-channel successor of the single-channel 3-phase PWM generator.
- One shared period counter; each channel has its own on-time request, min-pulse skip with carry-over of skipped and excess on-time, and per-step want/real accounting.
- Sits between the step sequencer (supplies sync/step_end/step_first strobes) and the MOS gate drivers.

---
 rtl/motoro3_pwm_multich_gen.sv | 146 ++++++++++++++
 tb/tb_motoro3_pwm_multich_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_pwm_multich_gen.sv
// motoro3_pwm_multich_gen
// NCH-channel PWM generator with a shared period counter. Each channel loads
// an on-time at every period reload, defers requests shorter than min_pulse,
// carries skipped/excess on-time forward, and accumulates requested versus
// delivered on-time per step. State updates on the falling edge of clk.
// Optional build macro: MOTORO3_PWM_LOST_COMP_EN. When defined, a step_first
// strobe folds a non-negative lost value from the previous step back into
// each enabled channel's carry-over.
module motoro3_pwm_multich_gen #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned CNT_W = 12,
  parameter int unsigned ACC_W = 16
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               active,
  input  logic               sync,
  input  logic               step_end,
  input  logic               step_first,
  input  logic [CNT_W-1:0]   period_len,
  input  logic [CNT_W-1:0]   min_pulse,
  input  logic [NCH*ACC_W-1:0] want,
  input  logic [NCH-1:0]     ch_en,
  output logic [NCH-1:0]     pwm,
  output logic               period_start,
  output logic [NCH*ACC_W-1:0] acc_want,
  output logic [NCH*ACC_W-1:0] acc_real,
  output logic [NCH*ACC_W-1:0] lost
);

  logic [CNT_W-1:0]            cnt;
  logic                        reload;
  logic [NCH-1:0][CNT_W-1:0]   pcnt;
  logic [NCH-1:0][ACC_W-1:0]   remain;
  logic [NCH-1:0][ACC_W-1:0]   aw;
  logic [NCH-1:0][ACC_W-1:0]   ar;
  logic [NCH-1:0][ACC_W-1:0]   sum;
  logic [NCH-1:0][ACC_W-1:0]   remain_nxt;
  logic [NCH-1:0][CNT_W-1:0]   pulse_ld;

  // Unsigned add clamped to the all-ones value instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  assign reload = active & (sync | (cnt <= CNT_W'(1)));

  // Gate drive follows the per-channel pulse counter directly.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      pwm[i] = (pcnt[i] != '0);
    end
  end

  // Per-channel load value and next carry-over at a reload edge.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      sum[i]        = sat_add(remain[i], want[i*ACC_W +: ACC_W]);
      pulse_ld[i]   = '0;
      remain_nxt[i] = remain[i];
      if (reload) begin
        if (!ch_en[i]) begin
          remain_nxt[i] = '0;
        end else if (sum[i] < ACC_W'(min_pulse)) begin
          remain_nxt[i] = sum[i];
        end else if (sum[i] < ACC_W'(period_len)) begin
          pulse_ld[i]   = CNT_W'(sum[i]);
          remain_nxt[i] = '0;
        end else begin
          pulse_ld[i]   = period_len;
          remain_nxt[i] = sum[i] - ACC_W'(period_len);
        end
      end
`ifdef MOTORO3_PWM_LOST_COMP_EN
      // step_end/!active override this in the register block below.
      if (step_first && ch_en[i] && !lost[i*ACC_W + ACC_W - 1]) begin
        remain_nxt[i] = sat_add(remain_nxt[i], lost[i*ACC_W +: ACC_W]);
      end
`endif
    end
  end

  // Shared period counter and the registered reload strobe.
  // Reset loads the live period_len so the first period has full length.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt          <= period_len;
      period_start <= 1'b0;
    end else begin
      period_start <= reload;
      if (!active || reload) begin
        cnt <= period_len;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Per-channel pulse counters, carry-over and step accounting.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      pcnt     <= '0;
      remain   <= '0;
      aw       <= '0;
      ar       <= '0;
      acc_want <= '0;
      acc_real <= '0;
      lost     <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!active) begin
          pcnt[i]   <= '0;
          remain[i] <= '0;
          aw[i]     <= '0;
          ar[i]     <= '0;
        end else begin
          if (reload) begin
            pcnt[i] <= pulse_ld[i];
          end else if (pcnt[i] != '0) begin
            pcnt[i] <= pcnt[i] - CNT_W'(1);
          end
          if (step_end) begin
            acc_want[i*ACC_W +: ACC_W] <= aw[i];
            acc_real[i*ACC_W +: ACC_W] <= ar[i];
            lost[i*ACC_W +: ACC_W]     <= aw[i] - ar[i];
            remain[i] <= '0;
            aw[i]     <= '0;
            ar[i]     <= '0;
          end else begin
            remain[i] <= remain_nxt[i];
            if (reload && ch_en[i]) begin
              aw[i] <= aw[i] + want[i*ACC_W +: ACC_W];
            end
            if (pwm[i]) begin
              ar[i] <= ar[i] + ACC_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_multich_gen.sv
// tb_motoro3_pwm_multich_gen
// Directed bench for motoro3_pwm_multich_gen. Inputs are driven and outputs
// sampled on the rising edge, half a cycle away from the falling active edge.
// Expectations for the deferred-error feature follow MOTORO3_PWM_LOST_COMP_EN.
module tb_motoro3_pwm_multich_gen;

  localparam int unsigned NCH   = 3;
  localparam int unsigned CNT_W = 12;
  localparam int unsigned ACC_W = 16;

  logic                   clk;
  logic                   nRst;
  logic                   active;
  logic                   sync;
  logic                   step_end;
  logic                   step_first;
  logic [CNT_W-1:0]       period_len;
  logic [CNT_W-1:0]       min_pulse;
  logic [NCH*ACC_W-1:0]   want;
  logic [NCH-1:0]         ch_en;
  logic [NCH-1:0]         pwm;
  logic                   period_start;
  logic [NCH*ACC_W-1:0]   acc_want;
  logic [NCH*ACC_W-1:0]   acc_real;
  logic [NCH*ACC_W-1:0]   lost;

  motoro3_pwm_multich_gen #(
    .NCH  (NCH),
    .CNT_W(CNT_W),
    .ACC_W(ACC_W)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .active      (active),
    .sync        (sync),
    .step_end    (step_end),
    .step_first  (step_first),
    .period_len  (period_len),
    .min_pulse   (min_pulse),
    .want        (want),
    .ch_en       (ch_en),
    .pwm         (pwm),
    .period_start(period_start),
    .acc_want    (acc_want),
    .acc_real    (acc_real),
    .lost        (lost)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int hi_cnt [NCH];
  int ps_cnt;
  int cur_run;
  int runs [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
    ps_cnt  = 0;
    cur_run = 0;
    runs.delete();
  endtask

  // Advance n falling edges, sampling at each following rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      @(posedge clk);
      for (int c = 0; c < NCH; c++) if (pwm[c]) hi_cnt[c]++;
      if (period_start) ps_cnt++;
      if (pwm[0]) cur_run++;
      else if (cur_run > 0) begin
        runs.push_back(cur_run);
        cur_run = 0;
      end
    end
  endtask

  function automatic int run_at(input int idx);
    if (idx < runs.size()) return runs[idx];
    return -1;
  endfunction

  int exp_comp_pulse;

  initial begin
`ifdef MOTORO3_PWM_LOST_COMP_EN
    exp_comp_pulse = 90;
`else
    exp_comp_pulse = 50;
`endif
    nRst       = 1'b0;
    active     = 1'b0;
    sync       = 1'b0;
    step_end   = 1'b0;
    step_first = 1'b0;
    period_len = 12'd100;
    min_pulse  = 12'd20;
    want       = {16'd0, 16'd77, 16'd50};
    ch_en      = 3'b001;
    clear_stats();

    // Reset state
    @(posedge clk);
    check("rst_pwm", 32'(pwm), 0);
    check("rst_pstart", 32'(period_start), 0);
    check("rst_acc_want", acc_want[31:0], 0);
    check("rst_lost", lost[31:0], 0);

    // 1: 50/100 duty, channel 1 disabled despite a nonzero request
    nRst   = 1'b1;
    active = 1'b1;
    sync   = 1'b1;
    step(1);
    sync = 1'b0;
    check("t1_pstart_first", 32'(period_start), 1);
    step(199);
    check("t1_hi0", hi_cnt[0], 100);
    check("t1_hi1", hi_cnt[1], 0);
    check("t1_hi2", hi_cnt[2], 0);
    check("t1_pstarts", ps_cnt, 2);
    check("t1_nruns", runs.size(), 2);
    check("t1_run0", run_at(0), 50);
    check("t1_run1", run_at(1), 50);

    // 2: short request deferred twice, then issued as 24
    clear_stats();
    want[15:0] = 16'd8;
    step(1);
    check("t2_remain8", dut.remain[0], 8);
    check("t2_skip_pwm", 32'(pwm[0]), 0);
    step(100);
    check("t2_remain16", dut.remain[0], 16);
    step(199);
    check("t2_remain0", dut.remain[0], 0);
    check("t2_nruns", runs.size(), 1);
    check("t2_run", run_at(0), 24);
    check("t2_hi0", hi_cnt[0], 24);

    // 3: excess on-time carried forward, then saturation of carry-over
    clear_stats();
    want[15:0] = 16'd150;
    step(1);
    check("t3_remain50", dut.remain[0], 50);
    step(100);
    check("t3_remain100", dut.remain[0], 100);
    step(99);
    check("t3_hi0", hi_cnt[0], 200);
    period_len = 12'd0;
    want[15:0] = 16'h4000;
    step(8);
    check("t3_sat", dut.remain[0], 32'h0000_FFFF);
    check("t3_sat_pwm", 32'(pwm[0]), 0);

    // 4: step accounting, full step then a step ended by a truncating sync
    period_len = 12'd100;
    want[15:0] = 16'd50;
    active     = 1'b0;
    step(1);
    check("t4_idle_pwm", 32'(pwm), 0);
    active = 1'b1;
    sync   = 1'b1;
    clear_stats();
    step(1);
    sync = 1'b0;
    step(298);
    step_end = 1'b1;
    step(1);
    step_end = 1'b0;
    check("t4_hi0", hi_cnt[0], 150);
    check("t4_acc_want", acc_want[15:0], 150);
    check("t4_acc_real", acc_real[15:0], 150);
    check("t4_lost", lost[15:0], 0);
    check("t4_acc_want1", acc_want[31:16], 0);
    step(201);
    step(10);
    check("t4_trunc_pwm", 32'(pwm[0]), 1);
    sync     = 1'b1;
    step_end = 1'b1;
    step(1);
    sync     = 1'b0;
    step_end = 1'b0;
    check("t4b_acc_want", acc_want[15:0], 150);
    check("t4b_acc_real", acc_real[15:0], 110);
    check("t4b_lost", lost[15:0], 40);

    // 5: lost on-time fed back at step_first (only with the build macro)
    step_first = 1'b1;
    step(1);
    step_first = 1'b0;
    step(98);
    clear_stats();
    step(100);
    check("t5_nruns", runs.size(), 1);
    check("t5_pulse", run_at(0), 32'(exp_comp_pulse));
    check("t5_remain", dut.remain[0], 0);

    // 6: drop active mid-pulse, then asynchronous reset mid-step
    step(11);
    check("t6_pulse_on", 32'(pwm[0]), 1);
    active = 1'b0;
    step(1);
    check("t6_inact_pwm", 32'(pwm), 0);
    check("t6_inact_pstart", 32'(period_start), 0);
    check("t6_hold_want", acc_want[15:0], 150);
    check("t6_hold_real", acc_real[15:0], 110);
    check("t6_hold_lost", lost[15:0], 40);
    check("t6_cnt_restart", 32'(dut.cnt), 100);
    active = 1'b1;
    sync   = 1'b1;
    step(1);
    sync = 1'b0;
    step(5);
    check("t6_pulse_again", 32'(pwm[0]), 1);
    nRst = 1'b0;
    #1;
    check("t6_rst_pwm", 32'(pwm), 0);
    check("t6_rst_want", acc_want[15:0], 0);
    check("t6_rst_real", acc_real[15:0], 0);
    check("t6_rst_lost", lost[15:0], 0);
    check("t6_rst_cnt", 32'(dut.cnt), 100);
    step(2);
    check("t6_rst_hold_pwm", 32'(pwm), 0);
    nRst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
